// File: rtl/skylark_pkg.sv
// skylark_pkg: shared types and constants for the fetch stage
package skylark_pkg;
  typedef enum logic [1:0] {PCSRC_SEQ = 2'b00, PCSRC_TAKEN = 2'b01, PCSRC_RECOVER = 2'b10} pcsrc_e;
  typedef enum logic [1:0] {IDLE, WAIT, HOLD, DISCARD} fetch_state_e;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with stall, flush and async active-low reset
module if_id_reg
  import skylark_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            load,
  input  logic            stall,
  input  logic            flush,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= XLEN'(4);
      ValidD   <= 1'b0;
    end else if (flush) begin
      InstrD <= NOP_INSTR;
      ValidD <= 1'b0;
    end else if (load && !stall) begin
      InstrD   <= instr;
      PCD      <= pc;
      PCPlus4D <= pc + XLEN'(4);
      ValidD   <= 1'b1;
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with one outstanding request, redirects and IF/ID register
module fetch_stage
  import skylark_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            nreset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic [1:0]      PCSrcE,
  input  logic [XLEN-1:0] BranchTargetE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic            StallD,
  input  logic            FlushD,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD,
  output logic            branched_flag_F
);
  fetch_state_e    state, state_n;
  logic            run, hs, taken, recover, redir, load, bflag, tgt_pend;
  logic [XLEN-1:0] pc_f, pc_sel, pc_n;
  logic [31:0]     skid;
  assign imem_req        = run && state == IDLE;
  assign imem_addr       = pc_f;
  assign hs              = imem_req && imem_gnt;
  assign taken           = PCSrcE == PCSRC_TAKEN;
  assign recover         = PCSrcE == PCSRC_RECOVER;
  assign redir           = taken || recover;
  assign load            = !redir && !StallD && (state == HOLD || (state == WAIT && imem_rvalid));
  assign branched_flag_F = bflag;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = hs ? (redir ? DISCARD : WAIT) : IDLE;
      WAIT:    state_n = imem_rvalid ? ((redir || !StallD) ? IDLE : HOLD) : (redir ? DISCARD : WAIT);
      HOLD:    state_n = (redir || !StallD) ? IDLE : HOLD;
      DISCARD: state_n = imem_rvalid ? IDLE : DISCARD;
      default: state_n = IDLE;
    endcase
    pc_sel = taken ? BranchTargetE : recover ? PCPlus4E : load ? pc_f + XLEN'(4) : pc_f;
    pc_n   = {pc_sel[XLEN-1:2], 2'b00};
  end
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      state    <= IDLE;
      pc_f     <= RESET_PC;
      run      <= 1'b0;
      skid     <= NOP_INSTR;
      bflag    <= 1'b0;
      tgt_pend <= 1'b0;
    end else begin
      state <= state_n;
      pc_f  <= pc_n;
      run   <= 1'b1;
      if (state == WAIT && imem_rvalid && StallD && !redir) skid <= imem_rdata;
      if (taken) begin
        bflag    <= 1'b1;
        tgt_pend <= 1'b1;
      end else if (recover) begin
        bflag    <= 1'b0;
        tgt_pend <= 1'b0;
      end else if (load) begin
        tgt_pend <= 1'b0;
        if (!tgt_pend) bflag <= 1'b0;
      end
    end
  if_id_reg #(.XLEN(XLEN)) u_if_id (
    .clk      (clk),
    .nreset   (nreset),
    .load     (load),
    .stall    (StallD),
    .flush    (FlushD),
    .instr    (state == HOLD ? skid : imem_rdata),
    .pc       (pc_f),
    .InstrD   (InstrD),
    .PCD      (PCD),
    .PCPlus4D (PCPlus4D),
    .ValidD   (ValidD)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed cycle-exact checks of fetch_stage against a simple memory model
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        imem_req, imem_gnt, ValidD, branched_flag_F;
  logic [31:0] imem_addr, InstrD, PCD, PCPlus4D;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [1:0]  PCSrcE = 2'b00;
  logic [31:0] BranchTargetE = '0, PCPlus4E = '0;
  logic        StallD = 1'b0, FlushD = 1'b0, gnt_en = 1'b1;
  int          lat = 0, cnt = 0, n_tests = 0, n_fail = 0;
  logic        busy = 1'b0;
  logic [31:0] a_q = '0;
  localparam logic [31:0] NOP = 32'h0000_0013;
  assign imem_gnt = gnt_en;
  fetch_stage dut (
    .clk             (clk),
    .nreset          (nreset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .PCSrcE          (PCSrcE),
    .BranchTargetE   (BranchTargetE),
    .PCPlus4E        (PCPlus4E),
    .StallD          (StallD),
    .FlushD          (FlushD),
    .InstrD          (InstrD),
    .PCD             (PCD),
    .PCPlus4D        (PCPlus4D),
    .ValidD          (ValidD),
    .branched_flag_F (branched_flag_F)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    imem_rvalid <= 1'b0;
    if (imem_req && imem_gnt) begin
      if (lat == 0) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= imem_addr;
      end else begin
        busy <= 1'b1;
        a_q  <= imem_addr;
        cnt  <= lat;
      end
    end else if (busy) begin
      if (cnt == 1) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= a_q;
        busy        <= 1'b0;
      end else cnt <= cnt - 1;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    step(2);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_instr", InstrD, NOP);
    chk("rst_pcd", PCD, 0);
    chk("rst_pcp4", PCPlus4D, 4);
    chk("rst_valid", ValidD, 0);
    chk("rst_bflag", branched_flag_F, 0);
    nreset = 1'b1;
    step(1);
    chk("t1_req", imem_req, 1);
    chk("t1_addr0", imem_addr, 0);
    step(2);
    chk("t1_instr0", InstrD, 0);
    chk("t1_valid", ValidD, 1);
    chk("t1_pcp4", PCPlus4D, 4);
    chk("t1_addr4", imem_addr, 4);
    step(2);
    chk("t1_instr4", InstrD, 4);
    chk("t1_addr8", imem_addr, 8);
    StallD = 1'b1;
    step(2);
    chk("t2_hold_instr", InstrD, 4);
    chk("t2_hold_req", imem_req, 0);
    step(1);
    chk("t2_hold_instr2", InstrD, 4);
    StallD = 1'b0;
    step(1);
    chk("t2_instr8", InstrD, 8);
    chk("t2_pcd8", PCD, 8);
    chk("t2_pcp4", PCPlus4D, 12);
    chk("t2_addr12", imem_addr, 12);
    lat = 2;
    step(1);
    PCSrcE = 2'b01;
    BranchTargetE = 32'h40;
    step(1);
    PCSrcE = 2'b00;
    chk("t3_addr40", imem_addr, 32'h40);
    chk("t3_discard_req", imem_req, 0);
    chk("t3_bflag", branched_flag_F, 1);
    step(1);
    lat = 0;
    step(1);
    chk("t3_dropped", InstrD, 8);
    chk("t3_req40", imem_req, 1);
    step(2);
    chk("t3_instr40", InstrD, 32'h40);
    chk("t3_bflag_tgt", branched_flag_F, 1);
    chk("t3_addr44", imem_addr, 32'h44);
    PCSrcE = 2'b10;
    PCPlus4E = 32'h14;
    step(1);
    PCSrcE = 2'b00;
    chk("t4_addr14", imem_addr, 32'h14);
    chk("t4_bflag", branched_flag_F, 0);
    step(1);
    chk("t4_req14", imem_req, 1);
    step(2);
    chk("t4_instr14", InstrD, 32'h14);
    step(1);
    FlushD = 1'b1;
    step(1);
    FlushD = 1'b0;
    chk("t5_valid", ValidD, 0);
    chk("t5_nop", InstrD, NOP);
    chk("t5_addr1c", imem_addr, 32'h1C);
    step(2);
    chk("t5_instr1c", InstrD, 32'h1C);
    chk("t5_valid1", ValidD, 1);
    gnt_en = 1'b0;
    PCSrcE = 2'b01;
    BranchTargetE = 32'h80;
    step(1);
    gnt_en = 1'b1;
    PCSrcE = 2'b00;
    chk("t7_addr80", imem_addr, 32'h80);
    chk("t7_bflag", branched_flag_F, 1);
    step(2);
    chk("t7_instr80", InstrD, 32'h80);
    chk("t7_bflag_tgt", branched_flag_F, 1);
    step(2);
    chk("t7_instr84", InstrD, 32'h84);
    chk("t7_bflag_clr", branched_flag_F, 0);
    gnt_en = 1'b0;
    step(2);
    chk("t7_nognt_addr", imem_addr, 32'h88);
    chk("t7_nognt_req", imem_req, 1);
    gnt_en = 1'b1;
    lat = 3;
    step(1);
    nreset = 1'b0;
    gnt_en = 1'b0;
    #1;
    chk("t6_instr", InstrD, NOP);
    chk("t6_valid", ValidD, 0);
    chk("t6_pcd", PCD, 0);
    chk("t6_pcp4", PCPlus4D, 4);
    chk("t6_addr", imem_addr, 0);
    chk("t6_req", imem_req, 0);
    step(1);
    nreset = 1'b1;
    step(3);
    chk("t6_late_valid", ValidD, 0);
    chk("t6_late_instr", InstrD, NOP);
    chk("t6_restart_addr", imem_addr, 0);
    chk("t6_restart_req", imem_req, 1);
    gnt_en = 1'b1;
    lat = 0;
    step(2);
    chk("t6_instr0", InstrD, 0);
    chk("t6_addr4", imem_addr, 4);
    PCSrcE = 2'b01;
    BranchTargetE = 32'hFFFF_FFFC;
    step(1);
    PCSrcE = 2'b00;
    step(3);
    chk("wrap_instr", InstrD, 32'hFFFF_FFFC);
    chk("wrap_pcp4", PCPlus4D, 0);
    chk("wrap_addr", imem_addr, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
